// File: rtl/matrix_bram_pkg.sv
// Shared constants and types for the matrix BRAM writer and reader.
package matrix_bram_pkg;

    // Memory organisation: fixed-size blocks, one matrix per block
    localparam int BLOCK_SIZE          = 1152;
    localparam int MAX_MEMORY_MATRIXES = 8;
    localparam int META_WORDS          = 3;

    // Word offsets of the metadata words inside a block
    localparam int META_DIMS_OFS    = 0;
    localparam int META_NAME_LO_OFS = 1;
    localparam int META_NAME_HI_OFS = 2;

    // Field positions inside the dimensions word {rows, cols, 16'h0}
    localparam int META_FIELD_WIDTH = 8;
    localparam int META_ROWS_LSB    = 24;
    localparam int META_COLS_LSB    = 16;

    // Writer sequencing states
    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        META0,
        META1,
        META2,
        DATA,
        DONE,
        ERR
    } writer_state_t;

endpackage

// File: rtl/matrix_writer.sv
// Streams one matrix (metadata + row-major elements) into its BRAM block.
module matrix_writer #(
    parameter int MAX_MEMORY_MATRIXES = matrix_bram_pkg::MAX_MEMORY_MATRIXES,
    parameter int BLOCK_SIZE          = matrix_bram_pkg::BLOCK_SIZE,
    parameter int DATA_WIDTH          = 32,
    parameter int ADDR_WIDTH          = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_req,
    input  logic [2:0]            matrix_id,
    input  logic [7:0]            rows,
    input  logic [7:0]            cols,
    input  logic [63:0]           matrix_name,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  writer_ready,
    output logic                  write_done,
    output logic                  write_error,
    output logic [7:0]            matrix_valid,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din
);
    import matrix_bram_pkg::*;

    localparam logic [15:0] MAX_ELEMS = 16'(BLOCK_SIZE - META_WORDS);

    writer_state_t         r_state;
    writer_state_t         w_nextState;
    logic [2:0]            r_id;
    logic [7:0]            r_rows;
    logic [7:0]            r_cols;
    logic [63:0]           r_name;
    logic [10:0]           r_product;
    logic [10:0]           r_count;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [7:0]            r_matrixValid;
    logic                  r_bramWe;
    logic [ADDR_WIDTH-1:0] r_bramAddr;
    logic [DATA_WIDTH-1:0] r_bramDin;

    logic [15:0]           w_fullProduct;
    logic                  w_requestOk;
    logic                  w_accept;
    logic                  w_lastElem;
    logic [31:0]           w_metaDims;
    logic [ADDR_WIDTH-1:0] w_blockBase;
    logic [ADDR_WIDTH-1:0] w_elemAddr;

    // Size check uses the full 16-bit product so large requests cannot alias into range
    always_comb begin
        w_fullProduct = {8'd0, r_rows} * {8'd0, r_cols};
        w_requestOk   = (r_rows != 8'd0) && (r_cols != 8'd0) &&
                        (w_fullProduct <= MAX_ELEMS) &&
                        (int'(r_id) < MAX_MEMORY_MATRIXES);
        w_blockBase   = ADDR_WIDTH'(int'(r_id) * BLOCK_SIZE);
        w_elemAddr    = r_base + ADDR_WIDTH'(META_WORDS) + ADDR_WIDTH'(r_count);
        w_metaDims    = '0;
        w_metaDims[META_ROWS_LSB +: META_FIELD_WIDTH] = r_rows;
        w_metaDims[META_COLS_LSB +: META_FIELD_WIDTH] = r_cols;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake/status outputs
    always_comb begin
        w_nextState  = r_state;
        data_ready   = 1'b0;
        writer_ready = 1'b0;
        write_done   = 1'b0;
        write_error  = 1'b0;
        w_accept     = 1'b0;
        w_lastElem   = 1'b0;
        case (r_state)
            IDLE: begin
                writer_ready = 1'b1;
                if (write_req) begin
                    w_nextState = CHECK;
                end
            end
            CHECK:   w_nextState = w_requestOk ? META0 : ERR;
            META0:   w_nextState = META1;
            META1:   w_nextState = META2;
            META2:   w_nextState = DATA;
            DATA: begin
                data_ready = (r_count < r_product);
                w_accept   = data_ready && data_valid;
                w_lastElem = w_accept && ((r_count + 11'd1) == r_product);
                if (w_lastElem) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                write_done  = 1'b1;
                w_nextState = IDLE;
            end
            ERR: begin
                write_error = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Request capture, element counting, valid bitmap and the registered BRAM port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id          <= '0;
            r_rows        <= '0;
            r_cols        <= '0;
            r_name        <= '0;
            r_product     <= '0;
            r_count       <= '0;
            r_base        <= '0;
            r_matrixValid <= '0;
            r_bramWe      <= 1'b0;
            r_bramAddr    <= '0;
            r_bramDin     <= '0;
        end else begin
            r_bramWe <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (write_req) begin
                        r_id   <= matrix_id;
                        r_rows <= rows;
                        r_cols <= cols;
                        r_name <= matrix_name;
                    end
                end
                CHECK: begin
                    r_product <= w_fullProduct[10:0];
                    r_count   <= '0;
                    r_base    <= w_blockBase;
                    if (w_requestOk) begin
                        r_matrixValid[r_id] <= 1'b0;
                    end
                end
                META0: begin
                    r_bramWe   <= 1'b1;
                    r_bramAddr <= r_base + ADDR_WIDTH'(META_DIMS_OFS);
                    r_bramDin  <= DATA_WIDTH'(w_metaDims);
                end
                META1: begin
                    r_bramWe   <= 1'b1;
                    r_bramAddr <= r_base + ADDR_WIDTH'(META_NAME_LO_OFS);
                    r_bramDin  <= DATA_WIDTH'(r_name[31:0]);
                end
                META2: begin
                    r_bramWe   <= 1'b1;
                    r_bramAddr <= r_base + ADDR_WIDTH'(META_NAME_HI_OFS);
                    r_bramDin  <= DATA_WIDTH'(r_name[63:32]);
                end
                DATA: begin
                    if (w_accept) begin
                        r_bramWe   <= 1'b1;
                        r_bramAddr <= w_elemAddr;
                        r_bramDin  <= data_in;
                        r_count    <= r_count + 11'd1;
                    end
                    if (w_lastElem) begin
                        r_matrixValid[r_id] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign matrix_valid = r_matrixValid;
    assign bram_we      = r_bramWe;
    assign bram_addr    = r_bramAddr;
    assign bram_din     = r_bramDin;

endmodule
